// File: rtl/ball_collision_pkg.sv
// ----------------------------------------------------------------------------
// ball_collision_pkg
//   Shared definitions for the ball collision detector slice: edge-bit
//   positions inside HitEdgeCode, the object-class enumeration used to index
//   the per-class pulse and reported-flag vectors, and the wormhole FSM state.
//   Imported by the edge encoder and by every ball's detector instance.
// ----------------------------------------------------------------------------
package ball_collision_pkg;

  // Bit positions inside HitEdgeCode.
  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

  // Width of the scan / position buses.
  localparam int COORD_W = 11;

  // Object classes; the enum value is the bit index in every per-class vector.
  typedef enum logic [2:0] {
    BRACKETS   = 3'd0,
    OBSTACLE   = 3'd1,
    BUMPER     = 3'd2,
    MOVING_OBS = 3'd3,
    WORMHOLE1  = 3'd4,
    WORMHOLE2  = 3'd5,
    LFLIPPER   = 3'd6,
    RFLIPPER   = 3'd7
  } obj_class_t;

  localparam int NUM_CLASSES = 8;

  // Wormhole teleport guard.
  typedef enum logic {
    WH_IDLE     = 1'b0,
    WH_COOLDOWN = 1'b1
  } wh_state_t;

endpackage : ball_collision_pkg

// File: rtl/ball_collision_detector_if.sv
// ----------------------------------------------------------------------------
// ball_collision_detector_if
//   Bundle between the VGA scan / object drawers and one collision detector.
//   master : scan side; drives frame marker, pixel position, ball position and
//            all drawing requests; observes the collision pulses.
//   slave  : detector side; consumes the drawing requests and produces the
//            one-clock collision pulses plus HitEdgeCode.
//   Signals:
//     startOfFrame                 one-clock pulse at frame start
//     pixelX, pixelY               current scan pixel (unsigned, 11 bit)
//     ballTopLeftX/Y               ball top-left corner (signed, 11 bit)
//     ballDR, <object>DR           per-pixel drawing requests
//     collision<Object>            one-clock collision pulses
//     HitEdgeCode                  [3]=left [2]=top [1]=right [0]=bottom
// ----------------------------------------------------------------------------
interface ball_collision_detector_if;

  logic               startOfFrame;
  logic        [10:0] pixelX;
  logic        [10:0] pixelY;
  logic signed [10:0] ballTopLeftX;
  logic signed [10:0] ballTopLeftY;

  logic ballDR;
  logic bracketsDR;
  logic obstacleDR;
  logic bumperDR;
  logic movingObstacleDR;
  logic wormhole1DR;
  logic wormhole2DR;
  logic leftFlipperDR;
  logic rightFlipperDR;

  logic collisionBrackets;
  logic collisionObstacle;
  logic collisionBumper;
  logic collisionMovingObstacle;
  logic collisionWormhole1;
  logic collisionWormhole2;
  logic collisionLeftFlipper;
  logic collisionRightFlipper;
  logic [3:0] HitEdgeCode;

  modport master (
    output startOfFrame, pixelX, pixelY, ballTopLeftX, ballTopLeftY,
    output ballDR, bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
    output wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
    input  collisionBrackets, collisionObstacle, collisionBumper,
    input  collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
    input  collisionLeftFlipper, collisionRightFlipper, HitEdgeCode
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, ballTopLeftX, ballTopLeftY,
    input  ballDR, bracketsDR, obstacleDR, bumperDR, movingObstacleDR,
    input  wormhole1DR, wormhole2DR, leftFlipperDR, rightFlipperDR,
    output collisionBrackets, collisionObstacle, collisionBumper,
    output collisionMovingObstacle, collisionWormhole1, collisionWormhole2,
    output collisionLeftFlipper, collisionRightFlipper, HitEdgeCode
  );

endinterface : ball_collision_detector_if

// File: rtl/hit_edge_encoder.sv
// ----------------------------------------------------------------------------
// hit_edge_encoder
//   Purely combinational. Locates the current scan pixel relative to the ball
//   sprite, reports whether it falls inside the sprite box, and flags which
//   edge bands of the sprite it lies in. Shared by every ball instance.
//   Ports:
//     pixelX, pixelY           in   current scan pixel, unsigned
//     ballTopLeftX/Y           in   sprite top-left corner, signed
//     inBox                    out  pixel lies inside the BALL_WIDTH x BALL_HEIGHT box
//     edgeCode                 out  [3]=left [2]=top [1]=right [0]=bottom
// ----------------------------------------------------------------------------
module hit_edge_encoder
  import ball_collision_pkg::*;
#(
  parameter int BALL_WIDTH  = 16,
  parameter int BALL_HEIGHT = 16,
  parameter int EDGE_BAND   = 4
) (
  input  logic        [COORD_W-1:0] pixelX,
  input  logic        [COORD_W-1:0] pixelY,
  input  logic signed [COORD_W-1:0] ballTopLeftX,
  input  logic signed [COORD_W-1:0] ballTopLeftY,
  output logic                      inBox,
  output logic        [3:0]         edgeCode
);

  localparam logic signed [COORD_W:0] ZERO       = '0;
  localparam logic signed [COORD_W:0] WIDTH      = (COORD_W+1)'(BALL_WIDTH);
  localparam logic signed [COORD_W:0] HEIGHT     = (COORD_W+1)'(BALL_HEIGHT);
  localparam logic signed [COORD_W:0] BAND       = (COORD_W+1)'(EDGE_BAND);
  localparam logic signed [COORD_W:0] RIGHT_FROM = (COORD_W+1)'(BALL_WIDTH - EDGE_BAND);
  localparam logic signed [COORD_W:0] BOT_FROM   = (COORD_W+1)'(BALL_HEIGHT - EDGE_BAND);

  logic signed [COORD_W:0] offX;
  logic signed [COORD_W:0] offY;

  // Pixel is zero-extended, corner sign-extended, so a ball partly off the
  // left/top of the screen still yields correct small offsets.
  assign offX = $signed({1'b0, pixelX}) - $signed({ballTopLeftX[COORD_W-1], ballTopLeftX});
  assign offY = $signed({1'b0, pixelY}) - $signed({ballTopLeftY[COORD_W-1], ballTopLeftY});

  // A drawing-request glitch outside the sprite box must never be reported.
  assign inBox = (offX >= ZERO) && (offX < WIDTH) &&
                 (offY >= ZERO) && (offY < HEIGHT);

  always_comb begin
    edgeCode              = '0;
    edgeCode[EDGE_LEFT]   = (offX <  BAND);
    edgeCode[EDGE_TOP]    = (offY <  BAND);
    edgeCode[EDGE_RIGHT]  = (offX >= RIGHT_FROM);
    edgeCode[EDGE_BOTTOM] = (offY >= BOT_FROM);
  end

endmodule : hit_edge_encoder

// File: rtl/ball_collision_detector.sv
// ----------------------------------------------------------------------------
// ball_collision_detector
//   Watches the per-pixel drawing requests during the VGA scan and emits a
//   one-clock collision pulse per object class whenever the ball and that
//   object are drawn on the same pixel, together with the HitEdgeCode of the
//   pixel that triggered it. Each class reports at most once per frame.
//   Wormholes are additionally guarded by a frame cooldown so a teleported
//   ball does not immediately bounce back through the partner wormhole.
//   Ports:
//     clk        in   system clock
//     resetN     in   asynchronous reset, active low
//     bus        slave side of ball_collision_detector_if (DR inputs,
//                collision pulses, HitEdgeCode)
//   Outputs are registered: an overlap at cycle N shows up at cycle N+1.
// ----------------------------------------------------------------------------
module ball_collision_detector
  import ball_collision_pkg::*;
#(
  parameter int BALL_WIDTH        = 16,
  parameter int BALL_HEIGHT       = 16,
  parameter int EDGE_BAND         = 4,
  parameter int WORMHOLE_COOLDOWN = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  ball_collision_detector_if.slave bus
);

  localparam int CNT_W = (WORMHOLE_COOLDOWN > 0) ? $clog2(WORMHOLE_COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] COUNT_LOAD = CNT_W'(WORMHOLE_COOLDOWN);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

  // Pixel geometry
  logic       inBox;
  logic [3:0] edgeCode;

  hit_edge_encoder #(
    .BALL_WIDTH (BALL_WIDTH),
    .BALL_HEIGHT(BALL_HEIGHT),
    .EDGE_BAND  (EDGE_BAND)
  ) u_hitEdgeEncoder (
    .pixelX      (bus.pixelX),
    .pixelY      (bus.pixelY),
    .ballTopLeftX(bus.ballTopLeftX),
    .ballTopLeftY(bus.ballTopLeftY),
    .inBox       (inBox),
    .edgeCode    (edgeCode)
  );

  // State
  logic [NUM_CLASSES-1:0] reportedQ;
  logic [NUM_CLASSES-1:0] pulseQ;
  logic [3:0]             edgeCodeQ;
  wh_state_t              whStateQ;
  logic [CNT_W-1:0]       whCountQ;

  // Next-state / combinational
  logic [NUM_CLASSES-1:0] objDR;
  logic [NUM_CLASSES-1:0] objOverlap;
  logic [NUM_CLASSES-1:0] flagsLive;
  logic [NUM_CLASSES-1:0] hitNow;
  logic [NUM_CLASSES-1:0] reportedNext;
  wh_state_t              whStateNext;
  logic [CNT_W-1:0]       whCountNext;

  // Gather the object drawing requests into one vector indexed by class.
  always_comb begin
    objDR             = '0;
    objDR[BRACKETS]   = bus.bracketsDR;
    objDR[OBSTACLE]   = bus.obstacleDR;
    objDR[BUMPER]     = bus.bumperDR;
    objDR[MOVING_OBS] = bus.movingObstacleDR;
    objDR[WORMHOLE1]  = bus.wormhole1DR;
    objDR[WORMHOLE2]  = bus.wormhole2DR;
    objDR[LFLIPPER]   = bus.leftFlipperDR;
    objDR[RFLIPPER]   = bus.rightFlipperDR;
  end

  // Collision decision and wormhole FSM next state.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    objOverlap  = objDR & {NUM_CLASSES{bus.ballDR & inBox}};
    // startOfFrame opens the new frame in this very cycle, so an overlap on
    // the first pixel of the frame is already eligible.
    flagsLive   = bus.startOfFrame ? '0 : reportedQ;
    hitNow      = objOverlap & ~flagsLive;
    whStateNext = whStateQ;
    whCountNext = whCountQ;

    case (whStateQ)
      WH_IDLE: begin
        // Both wormholes at once: wormhole1 wins, one teleport only.
        if (hitNow[WORMHOLE1]) hitNow[WORMHOLE2] = 1'b0;
        if (hitNow[WORMHOLE1] || hitNow[WORMHOLE2]) begin
          whStateNext = WH_COOLDOWN;
          whCountNext = COUNT_LOAD;
        end
      end
      WH_COOLDOWN: begin
        hitNow[WORMHOLE1] = 1'b0;
        hitNow[WORMHOLE2] = 1'b0;
        if (bus.startOfFrame) begin
          if (whCountQ <= COUNT_ONE) begin
            whCountNext = '0;
            whStateNext = WH_IDLE;
          end else begin
            whCountNext = whCountQ - COUNT_ONE;
          end
        end
      end
      default: begin
        whStateNext = WH_IDLE;
        whCountNext = '0;
      end
    endcase

    reportedNext = flagsLive | hitNow;
    // Holding the wormhole flags through the cooldown (including the frame
    // start that ends it) keeps the frame in which the FSM returns to IDLE
    // silent; wormholes re-arm on the following frame start.
    if (whStateQ == WH_COOLDOWN) begin
      reportedNext[WORMHOLE1] = 1'b1;
      reportedNext[WORMHOLE2] = 1'b1;
    end
  end

  // Wormhole FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      whStateQ <= WH_IDLE;
      whCountQ <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      whStateQ <= whStateNext;
      whCountQ <= whCountNext;
    end
  end

  // Flags, pulses and edge code.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      // NOTE: every register here is small control state and is reset, so a
      // mid-frame reset leaves no stale pulse or flag behind on release.
      reportedQ <= '0;
      pulseQ    <= '0;
      edgeCodeQ <= '0;
    end else begin
      reportedQ <= reportedNext;
      pulseQ    <= hitNow;
      if (|hitNow) edgeCodeQ <= edgeCode;
    end
  end

  // Outputs
  assign bus.collisionBrackets       = pulseQ[BRACKETS];
  assign bus.collisionObstacle       = pulseQ[OBSTACLE];
  assign bus.collisionBumper         = pulseQ[BUMPER];
  assign bus.collisionMovingObstacle = pulseQ[MOVING_OBS];
  assign bus.collisionWormhole1      = pulseQ[WORMHOLE1];
  assign bus.collisionWormhole2      = pulseQ[WORMHOLE2];
  assign bus.collisionLeftFlipper    = pulseQ[LFLIPPER];
  assign bus.collisionRightFlipper   = pulseQ[RFLIPPER];
  assign bus.HitEdgeCode             = edgeCodeQ;

endmodule : ball_collision_detector

// File: tb/tb_ball_collision_detector.sv
// ----------------------------------------------------------------------------
// tb_ball_collision_detector
//   Self-checking bench. A frame-number based reference model predicts the
//   pulses and HitEdgeCode; a compare process checks them on every falling
//   edge. Directed scenarios pin the model with hand-computed values, then a
//   randomized phase stresses random ball positions, DRs and resets.
// ----------------------------------------------------------------------------
module tb_ball_collision_detector;
  import ball_collision_pkg::*;

  localparam int BW = 16;
  localparam int BH = 16;
  localparam int EB = 4;
  localparam int WC = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  ball_collision_detector_if bus();

  ball_collision_detector #(
    .BALL_WIDTH(BW), .BALL_HEIGHT(BH), .EDGE_BAND(EB), .WORMHOLE_COOLDOWN(WC)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic cmpEn = 1'b0;
  logic [7:0] drVec = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] dutPulses();
    return {bus.collisionRightFlipper, bus.collisionLeftFlipper,
            bus.collisionWormhole2, bus.collisionWormhole1,
            bus.collisionMovingObstacle, bus.collisionBumper,
            bus.collisionObstacle, bus.collisionBrackets};
  endfunction

  // ---------------- reference model ----------------
  // A class may report when it has not reported in the current frame number;
  // a wormhole additionally needs the frame number to exceed the last
  // wormhole frame by more than the cooldown length.
  int         mFrame;
  int         mLastRep [8];
  int         mLastWh;
  logic [7:0] mPulse;
  logic [3:0] mCode;

  int         mCur, mOffX, mOffY;
  logic       mInBox;
  logic [3:0] mEdge;
  logic [7:0] mHit;

  always_comb begin
    mCur   = mFrame + (bus.startOfFrame ? 1 : 0);
    mOffX  = int'(bus.pixelX) - int'($signed(bus.ballTopLeftX));
    mOffY  = int'(bus.pixelY) - int'($signed(bus.ballTopLeftY));
    mInBox = (mOffX >= 0) && (mOffX < BW) && (mOffY >= 0) && (mOffY < BH);
    mEdge  = {mOffX < EB, mOffY < EB, mOffX >= BW - EB, mOffY >= BH - EB};
    mHit   = '0;
    for (int c = 0; c < 8; c++)
      mHit[c] = bus.ballDR && drVec[c] && mInBox && (mLastRep[c] != mCur);
    if (mCur <= mLastWh + WC) begin
      mHit[WORMHOLE1] = 1'b0;
      mHit[WORMHOLE2] = 1'b0;
    end
    if (mHit[WORMHOLE1]) mHit[WORMHOLE2] = 1'b0;
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mPulse <= '0;
      mCode  <= '0;
      mFrame <= 0;
      mLastWh <= -1000;
      for (int c = 0; c < 8; c++) mLastRep[c] <= -1;
    end else begin
      mPulse <= mHit;
      if (|mHit) mCode <= mEdge;
      mFrame <= mCur;
      for (int c = 0; c < 8; c++) if (mHit[c]) mLastRep[c] <= mCur;
      if (mHit[WORMHOLE1] || mHit[WORMHOLE2]) mLastWh <= mCur;
    end
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      check("model_pulses", 32'(dutPulses()), 32'(mPulse));
      check("model_code", 32'(bus.HitEdgeCode), 32'(mCode));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setBall(input int x, input int y);
    bus.ballTopLeftX = 11'(x);
    bus.ballTopLeftY = 11'(y);
  endtask

  // Drive one pixel cycle, then wait to just after the next falling edge.
  task automatic step(input logic sof, input int px, input int py,
                      input logic bdr, input logic [7:0] dr);
    bus.startOfFrame     = sof;
    bus.pixelX           = 11'(px);
    bus.pixelY           = 11'(py);
    bus.ballDR           = bdr;
    drVec                = dr;
    bus.bracketsDR       = dr[BRACKETS];
    bus.obstacleDR       = dr[OBSTACLE];
    bus.bumperDR         = dr[BUMPER];
    bus.movingObstacleDR = dr[MOVING_OBS];
    bus.wormhole1DR      = dr[WORMHOLE1];
    bus.wormhole2DR      = dr[WORMHOLE2];
    bus.leftFlipperDR    = dr[LFLIPPER];
    bus.rightFlipperDR   = dr[RFLIPPER];
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 8'h00);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    idle();
    idle();
    resetN = 1'b1;
    idle();
  endtask

  localparam logic [7:0] M_BRK = 8'h01;
  localparam logic [7:0] M_OBS = 8'h02;
  localparam logic [7:0] M_BMP = 8'h04;
  localparam logic [7:0] M_WH1 = 8'h10;
  localparam logic [7:0] M_WH2 = 8'h20;
  localparam logic [7:0] M_LFL = 8'h40;

  initial begin
    int cnt, cnt2, rx, ry, px, py;
    logic [7:0] rdr;
    setBall(100, 100);
    idle();
    idle();
    cmpEn = 1'b1;
    check("reset_pulses", 32'(dutPulses()), 32'h0);
    check("reset_code", 32'(bus.HitEdgeCode), 32'h0);
    resetN = 1'b1;
    idle();

    // 1) single left-edge bumper pixel
    step(1'b1, 0, 0, 1'b0, 8'h00);
    step(1'b0, 100, 108, 1'b1, M_BMP);
    check("t1_pulses", 32'(dutPulses()), 32'(M_BMP));
    check("t1_code", 32'(bus.HitEdgeCode), 32'b1000);
    idle();
    check("t1_width", 32'(dutPulses()), 32'h0);

    // 2) 40 bottom-band obstacle pixels per frame, two frames
    for (int f = 0; f < 2; f++) begin
      step(1'b1, 0, 0, 1'b0, 8'h00);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
        step(1'b0, 100 + (i % 16), 112 + (i / 16), 1'b1, M_OBS);
        cnt += int'(bus.collisionObstacle);
      end
      check("t2_one_per_frame", 32'(cnt), 32'd1);
      check("t2_bottom_bit", 32'(bus.HitEdgeCode[EDGE_BOTTOM]), 32'd1);
    end

    // 3) corner pixel, then interior pixel next frame
    step(1'b1, 0, 0, 1'b0, 8'h00);
    step(1'b0, 115, 115, 1'b1, M_BRK);
    check("t3_corner_pulse", 32'(bus.collisionBrackets), 32'd1);
    check("t3_corner_code", 32'(bus.HitEdgeCode), 32'b0011);
    step(1'b1, 0, 0, 1'b0, 8'h00);
    step(1'b0, 107, 107, 1'b1, M_BRK);
    check("t3_interior_pulse", 32'(bus.collisionBrackets), 32'd1);
    check("t3_interior_code", 32'(bus.HitEdgeCode), 32'b0000);

    // 4) wormhole cooldown over 20 frames
    doReset();
    cnt2 = 0;
    for (int f = 0; f < 20; f++) begin
      step(1'b1, 0, 0, 1'b0, 8'h00);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 104, 104, 1'b1, (f >= 1 && f <= 8) ? (M_WH1 | M_WH2) : M_WH1);
        cnt  += int'(bus.collisionWormhole1);
        cnt2 += int'(bus.collisionWormhole2);
      end
      idle();
      check($sformatf("t4_wh1_frame%0d", f), 32'(cnt),
            (f == 0 || f == 9 || f == 18) ? 32'd1 : 32'd0);
    end
    check("t4_wh2_total", 32'(cnt2), 32'd0);

    // 5) simultaneous classes, wormhole priority
    doReset();
    step(1'b1, 0, 0, 1'b0, 8'h00);
    step(1'b0, 100, 100, 1'b1, M_LFL | M_BMP);
    check("t5_both_pulses", 32'(dutPulses()), 32'(M_LFL | M_BMP));
    check("t5_shared_code", 32'(bus.HitEdgeCode), 32'b1100);
    step(1'b1, 0, 0, 1'b0, 8'h00);
    step(1'b0, 100, 104, 1'b1, M_WH1 | M_WH2);
    check("t5_wh_priority", 32'(dutPulses()), 32'(M_WH1));

    // 6) reset during cooldown with outputs active
    resetN = 1'b0;
    #1;
    check("t6_async_pulses", 32'(dutPulses()), 32'h0);
    check("t6_async_code", 32'(bus.HitEdgeCode), 32'h0);
    idle();
    resetN = 1'b1;
    idle();
    check("t6_no_release_pulse", 32'(dutPulses()), 32'h0);
    step(1'b0, 100, 104, 1'b1, M_WH1);
    check("t6_wh_allowed", 32'(dutPulses()), 32'(M_WH1));

    // Randomized phase
    for (int f = 0; f < 250; f++) begin
      rx = int'($urandom_range(0, 300)) - 8;
      ry = int'($urandom_range(0, 300)) - 8;
      setBall(rx, ry);
      for (int i = 0; i < 32; i++) begin
        if ($urandom_range(0, 999) == 0) resetN = 1'b0;
        else resetN = 1'b1;
        px = rx + int'($urandom_range(0, 23)) - 4;
        py = ry + int'($urandom_range(0, 23)) - 4;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        for (int b = 0; b < 8; b++) rdr[b] = ($urandom_range(0, 7) == 0);
        step(i == 0, px, py, $urandom_range(0, 4) != 0, rdr);
      end
    end
    resetN = 1'b1;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ball_collision_detector
